// File: rtl/xc_malu_pmul_seq.sv
// Shift-add sequencer for packed pmul/pmulh: one step per lane bit, low and high products together.
// Define XC_MALU_PMUL_SEQ_CLMUL_EN to build the carryless (GF(2)) accumulation path.
module xc_malu_pmul_seq (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        req_high,
    input  logic        req_carryless,
    input  logic        req_pw_16,
    input  logic        req_pw_8,
    input  logic        req_pw_4,
    input  logic        req_pw_2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [63:0] rsp_full,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] arg_q, arg_d;
    logic [31:0] rs1_q, rs1_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  pw_q, pw_d;
    logic        high_q, high_d;
    logic        err_q, err_d;

`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
    logic        cl_q, cl_d;
`else
    logic        unused_carryless;
    assign unused_carryless = req_carryless;
`endif

    logic [3:0]  req_pw;
    logic        pw_legal;
    logic [4:0]  last_count;
    logic [63:0] step_acc;
    wire  [63:0] step_w [4];

    assign req_pw   = {req_pw_16, req_pw_8, req_pw_4, req_pw_2};
    assign pw_legal = $onehot(req_pw);

    // One shift-add step for every lane width; index 0 is 16-bit lanes down to index 3 for 2-bit.
    genvar gi, gk;
    for (gi = 0; gi < 4; gi++) begin : g_width
        localparam int W = 16 >> gi;
        wire [63:0] nxt;
        for (gk = 0; gk < 32 / W; gk++) begin : g_lane
            logic [W-1:0]   hi;
            logic [W-1:0]   lo;
            logic [W-1:0]   mcand;
            logic [W:0]     sum;
            logic [2*W-1:0] shifted;

            assign hi    = acc_q[32 + gk*W +: W];
            assign lo    = acc_q[gk*W +: W];
            assign mcand = rs1_q[gk*W +: W];

            always_comb begin
                sum = {1'b0, hi};
                if (arg_q[gk*W]) begin
`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
                    if (cl_q) begin
                        sum = {1'b0, hi ^ mcand};
                    end else begin
                        sum = {1'b0, hi} + {1'b0, mcand};
                    end
`else
                    sum = {1'b0, hi} + {1'b0, mcand};
`endif
                end
            end

            assign shifted = (2*W)'({sum, lo} >> 1);
            assign nxt[32 + gk*W +: W] = shifted[2*W-1:W];
            assign nxt[gk*W +: W]      = shifted[W-1:0];
        end
        assign step_w[gi] = nxt;
    end

    always_comb begin
        last_count = 5'd0;
        step_acc   = acc_q;
        if (pw_q[3]) begin
            last_count = 5'd15;
            step_acc   = step_w[0];
        end else if (pw_q[2]) begin
            last_count = 5'd7;
            step_acc   = step_w[1];
        end else if (pw_q[1]) begin
            last_count = 5'd3;
            step_acc   = step_w[2];
        end else if (pw_q[0]) begin
            last_count = 5'd1;
            step_acc   = step_w[3];
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset || flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = pw_legal ? RUN : DONE;
            RUN:     if (count_q == last_count) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
    end

    always_comb begin
        acc_d   = acc_q;
        arg_d   = arg_q;
        rs1_d   = rs1_q;
        count_d = count_q;
        pw_d    = pw_q;
        high_d  = high_q;
        err_d   = err_q;
`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
        cl_d    = cl_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rs1_d   = req_rs1;
                    pw_d    = req_pw;
                    high_d  = req_high;
`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
                    cl_d    = req_carryless;
`endif
                    acc_d   = 64'd0;
                    count_d = 5'd0;
                    arg_d   = pw_legal ? req_rs2 : 32'd0;
                    err_d   = !pw_legal;
                end
            end
            RUN: begin
                acc_d   = step_acc;
                arg_d   = arg_q >> 1;
                count_d = count_q + 5'd1;
            end
            DONE: begin
                if (rsp_ready) err_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset || flush) begin
            acc_q   <= 64'd0;
            arg_q   <= 32'd0;
            rs1_q   <= 32'd0;
            count_q <= 5'd0;
            pw_q    <= 4'd0;
            high_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
            cl_q    <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            arg_q   <= arg_d;
            rs1_q   <= rs1_d;
            count_q <= count_d;
            pw_q    <= pw_d;
            high_q  <= high_d;
            err_q   <= err_d;
`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
            cl_q    <= cl_d;
`endif
        end
    end

    // Result outputs read zero outside DONE so reset and in-flight partial sums never leak out.
    assign rsp_err    = err_q;
    assign rsp_full   = rsp_valid ? acc_q : 64'd0;
    assign rsp_result = !rsp_valid ? 32'd0 : (high_q ? acc_q[63:32] : acc_q[31:0]);

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// Scoreboard bench for xc_malu_pmul_seq: driver pushes expected packed products, monitor pops and compares.
// Honours XC_MALU_PMUL_SEQ_CLMUL_EN the same way as the design.
module tb_xc_malu_pmul_seq;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic        req_high = 1'b0;
    logic        req_carryless = 1'b0;
    logic        req_pw_16 = 1'b0;
    logic        req_pw_8 = 1'b0;
    logic        req_pw_4 = 1'b0;
    logic        req_pw_2 = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [63:0] rsp_full;
    logic        rsp_err;

`ifdef XC_MALU_PMUL_SEQ_CLMUL_EN
    localparam bit CL_EN = 1'b1;
`else
    localparam bit CL_EN = 1'b0;
`endif

    xc_malu_pmul_seq dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_high      (req_high),
        .req_carryless (req_carryless),
        .req_pw_16     (req_pw_16),
        .req_pw_8      (req_pw_8),
        .req_pw_4      (req_pw_4),
        .req_pw_2      (req_pw_2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_full      (rsp_full),
        .rsp_err       (rsp_err)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] full;
        logic [31:0] result;
        logic        err;
        int          lat;
        int          acc_cyc;
        int          hold;
    } exp_t;

    exp_t sb[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-lane unsigned (or GF(2)) product by schoolbook long multiplication.
    function automatic logic [63:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input int w, input bit cl);
        logic [63:0] lo_all;
        logic [63:0] hi_all;
        logic [63:0] mask;
        logic [63:0] la;
        logic [63:0] lb;
        logic [63:0] p;
        lo_all = 64'd0;
        hi_all = 64'd0;
        mask   = (64'd1 << w) - 64'd1;
        for (int k = 0; k < 32 / w; k++) begin
            la = (64'(a) >> (k * w)) & mask;
            lb = (64'(b) >> (k * w)) & mask;
            p  = 64'd0;
            for (int i = 0; i < w; i++) begin
                if (lb[i]) p = cl ? (p ^ (la << i)) : (p + (la << i));
            end
            lo_all |= (p & mask) << (k * w);
            hi_all |= ((p >> w) & mask) << (k * w);
        end
        return {hi_all[31:0], lo_all[31:0]};
    endfunction

    task automatic applyStimulus(input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] pw,
                                 input bit high, input bit cl, input int hold);
        exp_t e;
        int   waitc;
        int   w;
        waitc = 0;
        @(negedge g_clk);
        while (!req_ready && waitc < 300) begin
            @(negedge g_clk);
            waitc++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: req_ready=%0b want 1", req_ready);
            return;
        end
        req_rs1       = rs1;
        req_rs2       = rs2;
        {req_pw_16, req_pw_8, req_pw_4, req_pw_2} = pw;
        req_high      = high;
        req_carryless = cl;
        req_valid     = 1'b1;
        @(posedge g_clk);
        #1;
        req_valid     = 1'b0;
        req_rs1       = $urandom;
        req_rs2       = $urandom;
        req_high      = 1'($urandom);
        req_carryless = 1'($urandom);
        {req_pw_16, req_pw_8, req_pw_4, req_pw_2} = 4'($urandom);
        if ($onehot(pw)) begin
            w        = pw[3] ? 16 : pw[2] ? 8 : pw[1] ? 4 : 2;
            e.full   = refModel(rs1, rs2, w, cl && CL_EN);
            e.result = high ? e.full[63:32] : e.full[31:0];
            e.err    = 1'b0;
            e.lat    = w + 1;
        end else begin
            e.full   = 64'd0;
            e.result = 32'd0;
            e.err    = 1'b1;
            e.lat    = 1;
        end
        e.acc_cyc = cyc;
        e.hold    = hold;
        sb.push_back(e);
    endtask

    // Monitor: compares each response, optionally stalls it, then completes the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge g_clk);
            if (rsp_valid && !g_reset) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: rsp_valid=%0b want 0", rsp_valid);
                    rsp_ready = 1'b1;
                    @(posedge g_clk);
                    #1;
                    rsp_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_result", rsp_result, e.result);
                    checkOutput("rsp_full", rsp_full, e.full);
                    checkOutput("rsp_err", rsp_err, e.err);
                    checkOutput("latency", cyc - e.acc_cyc + 1, e.lat);
                    for (int h = 0; h < e.hold; h++) begin
                        @(negedge g_clk);
                        checkOutput("hold_full", rsp_full, e.full);
                        checkOutput("hold_result", rsp_result, e.result);
                        checkOutput("hold_valid_ready", {rsp_valid, req_ready}, 2'b10);
                    end
                    rsp_ready = 1'b1;
                    @(posedge g_clk);
                    #1;
                    rsp_ready = 1'b0;
                    @(negedge g_clk);
                    checkOutput("post_handshake_valid_err", {rsp_valid, rsp_err, req_ready}, 3'b001);
                end
            end
        end
    end

    initial begin
        logic [3:0] pw;
        int         r;
        int         waitc;

        g_reset = 1'b1;
        req_valid = 1'b1;
        req_pw_8 = 1'b1;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        checkOutput("reset_ctrl", {req_ready, rsp_valid, rsp_err}, 3'b100);
        checkOutput("reset_full", rsp_full, 64'd0);
        checkOutput("reset_result", rsp_result, 32'd0);
        req_valid = 1'b0;
        req_pw_8 = 1'b0;
        g_reset = 1'b0;
        @(negedge g_clk);
        checkOutput("post_reset_ctrl", {req_ready, rsp_valid}, 2'b10);

        applyStimulus(32'h0003_0005, 32'h0007_0009, 4'b1000, 1'b0, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 1'b1, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b0, 0);
        applyStimulus(32'h0003_0003, 32'h0003_0003, 4'b1000, 1'b0, 1'b1, 0);
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 4'b0000, 1'b0, 1'b0, 0);
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 4'b1100, 1'b1, 1'b0, 0);
        applyStimulus($urandom, $urandom, 4'b0010, 1'b0, 1'b0, 5);

        // Flush part way through a pw8 operation: nothing must come out.
        @(negedge g_clk);
        waitc = 0;
        while (!req_ready && waitc < 300) begin
            @(negedge g_clk);
            waitc++;
        end
        req_rs1 = $urandom;
        req_rs2 = $urandom;
        {req_pw_16, req_pw_8, req_pw_4, req_pw_2} = 4'b0100;
        req_valid = 1'b1;
        @(posedge g_clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        flush = 1'b1;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        @(negedge g_clk);
        checkOutput("flush_ctrl", {req_ready, rsp_valid}, 2'b10);
        repeat (20) @(negedge g_clk);
        checkOutput("flush_quiet", {req_ready, rsp_valid}, 2'b10);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) pw = 4'b0001 << (r % 4);
            else       pw = 4'($urandom_range(0, 15));
            applyStimulus($urandom, $urandom, pw, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        waitc = 0;
        while (sb.size() != 0 && waitc < 500) begin
            @(negedge g_clk);
            waitc++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: pending=%0d want 0", sb.size());
        end
        repeat (4) @(negedge g_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
